cjb_pipe_reg_chain: RTL and testbench

CJB_PIPE_REG_CHAIN -- requirements
Module: cjb_pipe_reg_chain

---
 rtl/cjb_pkg.sv | 13 +
 rtl/cjb_pipe_stage.sv | 51 +++++
 rtl/cjb_pipe_reg_chain.sv | 85 ++++++++
 tb/tb_cjb_pipe_reg_chain.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cjb_pkg.sv
// Shared constants and helpers for the cjb pipeline register chain.
// Holds default geometry and the occupancy counter width function.
package cjb_pkg;

    localparam int CJB_DEF_WIDTH  = 8;
    localparam int CJB_DEF_STAGES = 3;

    // Bits needed to count 0..stages valid words.
    function automatic int cjb_occ_width(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/cjb_pipe_stage.sv
// One valid/data register stage with ready flowing back upstream.
// A stage accepts when empty or when its word leaves this cycle.
module cjb_pipe_stage
    import cjb_pkg::*;
#(
    parameter int               WIDTH     = CJB_DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             up_ready,
    input  logic             dn_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             w_ready;
    logic             w_load;

    assign w_ready  = !r_valid || dn_ready;
    assign w_load   = up_valid && w_ready && !flush;
    assign up_ready = w_ready;
    assign valid    = r_valid;
    assign data     = r_data;

    // Valid bit: flush empties, otherwise refill (or drain) when ready.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_ready) begin
            r_valid <= up_valid;
        end
    end

    // Data loads only on a real transfer; it is never cleared.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= RESET_VAL;
        end else if (w_load) begin
            r_data <= up_data;
        end
    end

endmodule

// File: rtl/cjb_pipe_reg_chain.sv
// Valid/ready pipeline register chain of STAGES cjb_pipe_stage slices.
// Optional occupancy count port enabled by CJB_PIPE_OCCUPANCY_EN.
module cjb_pipe_reg_chain
    import cjb_pkg::*;
#(
    parameter int               WIDTH     = CJB_DEF_WIDTH,
    parameter int               STAGES    = CJB_DEF_STAGES,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
`ifdef CJB_PIPE_OCCUPANCY_EN
    output logic [cjb_occ_width(STAGES)-1:0] occupancy,
`endif
    input  logic             out_ready
);

    logic [STAGES-1:0] w_valid;
    logic [STAGES-1:0] w_ready;
    logic [STAGES-1:0] w_up_valid;
    logic [STAGES-1:0] w_dn_ready;
    logic [WIDTH-1:0]  w_data    [STAGES];
    logic [WIDTH-1:0]  w_up_data [STAGES];

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign w_up_valid[k] = in_valid;
                assign w_up_data[k]  = in_data;
            end else begin : g_mid
                assign w_up_valid[k] = w_valid[k-1];
                assign w_up_data[k]  = w_data[k-1];
            end

            if (k == STAGES - 1) begin : g_tail
                assign w_dn_ready[k] = out_ready;
            end else begin : g_link
                assign w_dn_ready[k] = w_ready[k+1];
            end

            cjb_pipe_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clock    (clock),
                .reset_n  (reset_n),
                .flush    (flush),
                .up_valid (w_up_valid[k]),
                .up_data  (w_up_data[k]),
                .up_ready (w_ready[k]),
                .dn_ready (w_dn_ready[k]),
                .valid    (w_valid[k]),
                .data     (w_data[k])
            );
        end
    endgenerate

    assign in_ready  = w_ready[0] && !flush;
    assign out_valid = w_valid[STAGES-1];
    assign out_data  = w_data[STAGES-1];

`ifdef CJB_PIPE_OCCUPANCY_EN
    localparam int OCC_W = cjb_occ_width(STAGES);

    logic [OCC_W-1:0] w_occ;

    // Popcount of the stage valid bits.
    always_comb begin
        w_occ = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_occ = w_occ + OCC_W'(w_valid[i]);
        end
    end

    assign occupancy = w_occ;
`endif

endmodule

// File: tb/tb_cjb_pipe_reg_chain.sv
// Scoreboard bench for cjb_pipe_reg_chain (WIDTH=8, STAGES=3).
// Optional occupancy checks when CJB_PIPE_OCCUPANCY_EN is defined.
module tb_cjb_pipe_reg_chain;

    localparam int         W  = 8;
    localparam int         S  = 3;
    localparam logic [7:0] RV = 8'hC3;

    logic       clock     = 1'b0;
    logic       reset_n   = 1'b0;
    logic       flush     = 1'b0;
    logic       in_valid  = 1'b0;
    logic [7:0] in_data   = 8'h00;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
`ifdef CJB_PIPE_OCCUPANCY_EN
    logic [1:0] occupancy;
    logic       in_valid2  = 1'b0;
    logic       in_ready2;
    logic       out_valid2;
    logic [7:0] out_data2;
    logic [2:0] occupancy2;
`endif

    cjb_pipe_reg_chain #(
        .WIDTH     (W),
        .STAGES    (S),
        .RESET_VAL (RV)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
`ifdef CJB_PIPE_OCCUPANCY_EN
        .occupancy (occupancy),
`endif
        .out_ready (out_ready)
    );

`ifdef CJB_PIPE_OCCUPANCY_EN
    cjb_pipe_reg_chain #(
        .WIDTH     (W),
        .STAGES    (4),
        .RESET_VAL (RV)
    ) dut4 (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (1'b0),
        .in_valid  (in_valid2),
        .in_data   (8'h3C),
        .in_ready  (in_ready2),
        .out_valid (out_valid2),
        .out_data  (out_data2),
        .occupancy (occupancy2),
        .out_ready (1'b0)
    );
`endif

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [7:0] sb_q[$];
    int         pop_cyc[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a word leaves at the next edge when valid && ready.
    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            check("sb_has_expected", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                check("out_data_order", 64'(out_data), 64'(sb_q.pop_front()));
            end
            pop_cyc.push_back(cyc);
        end
    end

    task automatic send(input logic [7:0] d, output int acc);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("send_timeout", 64'd0, 64'd1);
            acc      = -1;
            in_valid = 1'b0;
        end else begin
            acc = cyc + 1;
            @(posedge clock);
            sb_q.push_back(d);
            #1;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        reset_n   = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, e1, e2, e;
        int got;

        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'(RV));
        check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef CJB_PIPE_OCCUPANCY_EN
        check("rst_occupancy", 64'(occupancy), 64'd0);
`endif
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Three words back to back, latency STAGES-1 after accept
        out_ready = 1'b1;
        pop_cyc.delete();
        send(8'h11, e0);
        send(8'h22, e1);
        send(8'h33, e2);
        idle(6);
        check("t1_accept_gap", 64'(e1 - e0), 64'd1);
        check("t1_pop_count", 64'(pop_cyc.size()), 64'd3);
        if (pop_cyc.size() == 3) begin
            check("t1_first_latency", 64'(pop_cyc[0] - e0), 64'd2);
            check("t1_second_cyc", 64'(pop_cyc[1] - e0), 64'd3);
            check("t1_third_cyc", 64'(pop_cyc[2] - e0), 64'd4);
        end

        // Stall with a stream of six words, then release
        do_reset();
        pop_cyc.delete();
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(8'hA0 + 8'(i), e);
                end
                idle(1);
            end
            begin
                got = 0;
                for (int i = 0; i < 40; i++) begin
                    @(negedge clock);
                    if (sb_q.size() == 3) begin
                        got = 1;
                        break;
                    end
                end
                check("t2_fill_three", 64'(got), 64'd1);
                for (int i = 0; i < 3; i++) begin
                    check("t2_full_in_ready", 64'(in_ready), 64'd0);
                    check("t2_hold_valid", 64'(out_valid), 64'd1);
                    check("t2_hold_data", 64'(out_data), 64'hA0);
                    @(negedge clock);
                end
                @(posedge clock);
                #1;
                out_ready = 1'b1;
                @(negedge clock);
                check("t2_full_accept", 64'(in_ready), 64'd1);
            end
        join
        idle(6);
        check("t2_pop_count", 64'(pop_cyc.size()), 64'd6);
        if (pop_cyc.size() == 6) begin
            for (int i = 1; i < 6; i++) begin
                check("t2_no_gap", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'd1);
            end
        end

        // Flush with two words in flight and a word offered
        do_reset();
        send(8'h01, e);
        send(8'h02, e);
        idle(3);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        flush    = 1'b1;
        @(negedge clock);
        check("t3_flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clock);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb_q.delete();
        @(negedge clock);
        check("t3_out_valid", 64'(out_valid), 64'd0);
        check("t3_data_held", 64'(out_data), 64'h01);
        check("t3_in_ready", 64'(in_ready), 64'd1);
`ifdef CJB_PIPE_OCCUPANCY_EN
        check("t3_occupancy", 64'(occupancy), 64'd0);
`endif
        pop_cyc.delete();
        out_ready = 1'b1;
        idle(6);
        check("t3_nothing_out", 64'(pop_cyc.size()), 64'd0);

        // Asynchronous reset with the chain full
        do_reset();
        send(8'hB1, e);
        send(8'hB2, e);
        send(8'hB3, e);
        idle(1);
        @(negedge clock);
        check("t4_full_before", 64'(out_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t4_async_valid", 64'(out_valid), 64'd0);
        check("t4_async_data", 64'(out_data), 64'(RV));
        sb_q.delete();
        @(negedge clock);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        pop_cyc.delete();
        send(8'h77, e0);
        idle(5);
        check("t4_post_count", 64'(pop_cyc.size()), 64'd1);
        if (pop_cyc.size() == 1) begin
            check("t4_post_latency", 64'(pop_cyc[0] - e0), 64'd2);
        end

`ifdef CJB_PIPE_OCCUPANCY_EN
        // Four-stage chain stalled: occupancy climbs then holds
        @(posedge clock);
        #1;
        in_valid2 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clock);
            @(negedge clock);
            check("t5_occupancy", 64'(occupancy2), 64'(k < 4 ? k : 4));
        end
        check("t5_full_ready", 64'(in_ready2), 64'd0);
        in_valid2 = 1'b0;
`endif

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
